// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops words from a yumi-style fifo and shifts them out as UART frames
module uart_tx_drain #(
  parameter int width_p = 8,
  parameter int clks_per_bit_p = 104,
  parameter int parity_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               tx_o,
  output logic               busy_o
);
  localparam int bw = $clog2(clks_per_bit_p);
  localparam int iw = $clog2(width_p);
  localparam logic [bw-1:0] cnt_last = bw'(clks_per_bit_p - 1);
  localparam logic [iw-1:0] idx_last = iw'(width_p - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state, state_n;
  logic [bw-1:0] cnt, cnt_n;
  logic [iw-1:0] idx, idx_n;
  logic [width_p-1:0] sh, sh_n;
  logic par, par_n, tx_q, tx_n, last;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      par <= par_n;
      tx_q <= tx_n;
    end
  assign last = cnt == cnt_last;
  assign yumi_o = valid_i & ~reset_i & (state == IDLE | (state == STOP & last));
  assign tx_o = tx_q;
  assign busy_o = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || last) ? '0 : cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    par_n = par;
    unique case (state)
      IDLE: state_n = yumi_o ? START : IDLE;
      START: begin
        state_n = last ? DATA : START;
        idx_n = last ? '0 : idx;
      end
      DATA:
        if (last) begin
          sh_n = sh >> 1;
          idx_n = idx + 1'b1;
          state_n = idx != idx_last ? DATA : (parity_p != 0 ? PARITY : STOP);
        end
      PARITY: state_n = last ? STOP : PARITY;
      STOP: state_n = last ? (yumi_o ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
    if (yumi_o) begin
      sh_n = data_i;
      par_n = (^data_i) ^ (parity_p == 2);
    end
    tx_n = state_n == START ? 1'b0 :
           state_n == DATA ? sh_n[0] :
           state_n == PARITY ? par_n : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: checks three instances (no/even/odd parity) against a bit-level frame model
module tb_uart_tx_drain;
  logic clk = 0, rst = 1;
  logic [2:0] valid = '0, yumi, tx, busy;
  logic [7:0] data [3];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_drain #(.width_p(8), .clks_per_bit_p(4), .parity_p(g)) dut (
      .clk_i(clk), .reset_i(rst), .valid_i(valid[g]), .data_i(data[g]),
      .yumi_o(yumi[g]), .tx_o(tx[g]), .busy_o(busy[g]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic exp_bit(input logic [7:0] d, input int p, input int k);
    logic [7:0] dd;
    dd = d;
    if (k == 0) return 1'b0;
    if (k <= 8) return dd[k-1];
    if (k == 9 && p != 0) return ($countones(dd) % 2 == 1) ^ (p == 2);
    return 1'b1;
  endfunction
  function automatic int flen(input int p);
    return (10 + (p != 0 ? 1 : 0)) * 4;
  endfunction
  task automatic pop(input int p, input logic [7:0] d);
    @(negedge clk);
    valid[p] = 1'b1;
    data[p] = d;
    #1 chk("pop_yumi", yumi[p], 1);
  endtask
  task automatic body(input int p, input logic [7:0] d, input bit glitch);
    int f;
    f = flen(p);
    for (int t = 0; t < f; t++) begin
      @(negedge clk);
      valid[p] = (glitch && t < f - 1) ? 1'($urandom % 2) : 1'b0;
      if (glitch) data[p] = 8'($urandom);
      #1;
      chk($sformatf("tx p%0d t%0d", p, t), tx[p], exp_bit(d, p, t / 4));
      chk("busy_frame", busy[p], 1);
      chk("no_extra_yumi", yumi[p], 0);
    end
    @(negedge clk);
    #1;
    chk("busy_after", busy[p], 0);
    chk("tx_after", tx[p], 1);
  endtask
  initial begin
    logic [7:0] bq [$];
    logic [7:0] sent [3];
    logic [7:0] d;
    int f;
    for (int i = 0; i < 3; i++) data[i] = '0;
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx", tx[i], 1);
      chk("rst_busy", busy[i], 0);
      chk("rst_yumi", yumi[i], 0);
    end
    rst = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      chk("idle_tx", tx[0], 1);
      chk("idle_busy", busy[0], 0);
      chk("idle_yumi", yumi[0], 0);
    end
    for (int p = 0; p < 3; p++) begin
      pop(p, 8'hA5);
      body(p, 8'hA5, 0);
    end
    for (int n = 0; n < 6; n++) begin
      int p;
      p = n % 3;
      d = 8'($urandom);
      pop(p, d);
      body(p, d, n >= 3);
    end
    bq = '{8'h00, 8'hFF, 8'h3C};
    sent = '{8'h00, 8'hFF, 8'h3C};
    for (int i = 0; i <= 121; i++) begin
      @(negedge clk);
      valid[0] = bq.size() > 0;
      data[0] = bq.size() > 0 ? bq[0] : 8'h00;
      #1;
      if (i <= 120) chk($sformatf("b2b_yumi i%0d", i), yumi[0], (i == 0 || i == 40 || i == 80) ? 1 : 0);
      if (i >= 1 && i <= 120)
        chk($sformatf("b2b_tx i%0d", i), tx[0], exp_bit(sent[(i-1)/40], 0, ((i-1) % 40) / 4));
      if (i == 121) begin
        chk("b2b_busy_end", busy[0], 0);
        chk("b2b_tx_end", tx[0], 1);
      end
      if (yumi[0] && bq.size() > 0) void'(bq.pop_front());
    end
    valid[0] = 0;
    pop(0, 8'h55);
    for (int t = 0; t < 17; t++) begin
      @(negedge clk);
      valid[0] = 0;
      #1 chk("pre_rst_tx", tx[0], exp_bit(8'h55, 0, t / 4));
    end
    #1 rst = 1;
    #1;
    chk("async_rst_tx", tx[0], 1);
    chk("async_rst_busy", busy[0], 0);
    d = 8'($urandom);
    valid[0] = 1;
    data[0] = d;
    #1 chk("rst_yumi_gated", yumi[0], 0);
    @(negedge clk);
    rst = 0;
    #1 chk("post_rst_pop", yumi[0], 1);
    body(0, d, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Serial transmitter that drains bytes from a fifo producer interface (valid_o/data_o/yumi_i) and shifts them out as 8N1-style UART frames on a single pin.
- Sits between the fifo output side and the icebreaker UART TX pin; the host sees results as the fifo is emptied.
- Pops one word per frame via a yumi-style handshake.
- Supports optional parity and fully back-to-back frames.

Parameters:
- width_p, 8, data bits per frame, legal 5..16, sent LSB first.
- clks_per_bit_p, 104, clk_i cycles per serial bit (12 MHz / 115200), legal >= 2.
- parity_p, 0, parity mode: 0 none, 1 even, 2 odd; other values illegal.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous active-high reset
- valid_i  input  1  word available from the upstream producer (connect to fifo valid_o)
- data_i  input  width_p  word to send (connect to fifo data_o)
- yumi_o  output  1  word consumed this cycle (connect to fifo yumi_i)
- tx_o  output  1  serial line, idle high
- busy_o  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active-high.
- While reset_i is high:
  - tx_o = 1, busy_o = 0, yumi_o = 0, state = IDLE, all counters = 0.
  - Reset mid-frame aborts the frame. The partially sent word is lost and not re-popped.
  - tx_o returns high immediately; no stop-bit completion.
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when parity_p = 0.
- Baud counter:
  - baud_cnt counts 0..clks_per_bit_p-1 in every non-IDLE state.
  - Width is $clog2(clks_per_bit_p).
  - A bit ends when baud_cnt == clks_per_bit_p-1. At that point baud_cnt clears and the state/bit index advances.
- Handshake:
  - yumi_o = valid_i & ~reset_i & (state==IDLE | (state==STOP & baud_cnt==clks_per_bit_p-1)).
  - yumi_o is combinational from valid_i and registered state. It must never assert when valid_i = 0.
  - On the yumi_o cycle, data_i is captured into the shift register, parity is computed from data_i, and state becomes START at the next edge.
- Line timing:
  - tx_o is driven from a register (glitch-free).
  - START drives 0 for clks_per_bit_p cycles.
  - DATA drives bit bit_idx = 0..width_p-1 (LSB first), clks_per_bit_p cycles each.
  - PARITY drives the parity bit for clks_per_bit_p cycles: even = XOR of data, odd = ~XOR.
  - STOP drives 1 for clks_per_bit_p cycles.
- Latency: tx_o falls exactly 1 cycle after the yumi_o cycle.
- Frame length: F = (2 + width_p + (parity_p!=0)) * clks_per_bit_p cycles.
- Back-to-back:
  - If valid_i is high during the last STOP cycle, the next word is popped there. START follows with no extra idle cycle.
  - Sustained throughput is one word per F cycles.
- End of frame: if valid_i is low at the end of STOP, go to IDLE. tx_o stays 1 until the next valid_i.
- Data stability: data_i/valid_i changes while busy (other than at the STOP pop point) are ignored. Captured data is never modified mid-frame.
- Upstream empty: valid_i = 0 in IDLE leaves the block in IDLE indefinitely with tx_o = 1, yumi_o = 0.

Test Plan:
- Reset then idle (clks_per_bit_p=4, parity_p=0, valid_i=0 for 100 cycles) -> tx_o=1, yumi_o=0, busy_o=0 throughout.
- Single word 0xA5, parity_p=0, clks_per_bit_p=4 -> yumi_o high 1 cycle. tx_o pattern per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1 (40 cycles). busy_o drops after stop.
- Even/odd parity, 0xA5 (popcount 4) -> parity bit 0 with parity_p=1, 1 with parity_p=2; frame is 44 cycles.
- Back-to-back: fifo preloaded with 0x00, 0xFF, 0x3C, valid_i held high -> three yumi_o pulses spaced exactly 40 cycles apart. No idle-high gap between a stop bit and the next start bit. Decoded bytes match in order.
- Reset mid-DATA (assert reset_i during bit 3 of 0x55) -> tx_o=1 and busy_o=0 the same cycle without waiting for a clock edge. After release with valid_i high, the next word pops and a clean frame is sent.
- valid_i glitch while busy (toggle valid_i and data_i mid-frame) -> no extra yumi_o. Transmitted bits equal the originally captured word.
